// File: rtl/alu_sequencer_if.sv
// Command handshake between a command source and the ALU micro-sequencer.
// The master drives a command and its valid; the sequencer answers with ready.
interface alu_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic       cmd_asrc;
  logic [1:0] cmd_bsrc;
  logic [1:0] cmd_cin;
  logic       cmd_dec;
  logic [1:0] cmd_dst;

  modport master (
    output cmd_valid, cmd_op, cmd_asrc, cmd_bsrc, cmd_cin, cmd_dec, cmd_dst,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_asrc, cmd_bsrc, cmd_cin, cmd_dec, cmd_dst,
    output cmd_ready
  );
endinterface

// File: rtl/alu_sequencer.sv
// ALU micro-sequencer: runs LOAD / EXEC / DRIVE for one ALU operation per
// accepted command, generating latch, op-select, carry, BCD and result-drive
// strobes from a registered copy of the command. Keeps a carry register for
// ROR and carry chaining between commands.
module alu_sequencer (
  input  logic CLK,
  input  logic n_RES,
  input  logic RDY,
  input  logic n_COUT,
  alu_sequencer_if.slave cmd,
  output logic Z_ADD,
  output logic SB_ADD,
  output logic DB_ADD,
  output logic NDB_ADD,
  output logic ADL_ADD,
  output logic SUMS,
  output logic ANDS,
  output logic ORS,
  output logic EORS,
  output logic SRS,
  output logic n_ACIN,
  output logic n_DAA,
  output logic n_DSA,
  output logic ADD_SB06,
  output logic ADD_SB7,
  output logic ADD_ADL,
  output logic ROR_EN,
  output logic ROR_BIT7,
  output logic c_reg,
  output logic done,
  output logic err
);

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, DRIVE} state_t;

  localparam logic [2:0] OP_SUM = 3'd0;
  localparam logic [2:0] OP_AND = 3'd1;
  localparam logic [2:0] OP_OR  = 3'd2;
  localparam logic [2:0] OP_EOR = 3'd3;
  localparam logic [2:0] OP_SR  = 3'd4;
  localparam logic [2:0] OP_ROR = 3'd5;

  state_t     state_q, state_d;
  logic [2:0] op_q;
  logic       asrc_q;
  logic [1:0] bsrc_q;
  logic [1:0] cin_q;
  logic       dec_q;
  logic [1:0] dst_q;
  logic       illegal_q;
  logic       c_reg_q;
  logic       shadow_q;   // carry as it was when this command started (ROR bit 7)

  logic accept;
  logic cmd_illegal;
  logic is_ror;
  logic writes_carry;

  assign cmd.cmd_ready = (state_q == IDLE) | ((state_q == DRIVE) & RDY);
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;
  assign cmd_illegal   = (cmd.cmd_op > OP_ROR) | (cmd.cmd_bsrc == 2'd3);
  assign is_ror        = (op_q == OP_ROR);
  assign writes_carry  = (op_q == OP_SUM) | (op_q == OP_SR) | (op_q == OP_ROR);
  assign c_reg         = c_reg_q;

  // State register; a low RDY freezes every step except IDLE.
  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state sequencing: IDLE -> LOAD -> EXEC -> DRIVE -> (LOAD | IDLE).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOAD;
      LOAD:    if (RDY) state_d = EXEC;
      EXEC:    if (RDY) state_d = DRIVE;
      DRIVE:   if (RDY) state_d = accept ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the command on accept so strobes never see the live command bus.
  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      op_q      <= 3'd0;
      asrc_q    <= 1'b0;
      bsrc_q    <= 2'd0;
      cin_q     <= 2'd0;
      dec_q     <= 1'b0;
      dst_q     <= 2'd0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      op_q      <= cmd.cmd_op;
      asrc_q    <= cmd.cmd_asrc;
      bsrc_q    <= cmd.cmd_bsrc;
      cin_q     <= cmd.cmd_cin;
      dec_q     <= cmd.cmd_dec;
      dst_q     <= cmd.cmd_dst;
      illegal_q <= cmd_illegal;
    end
  end

  // Carry register and its start-of-command shadow for ROR.
  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      c_reg_q  <= 1'b0;
      shadow_q <= 1'b0;
    end else begin
      if (state_q == LOAD && RDY) shadow_q <= c_reg_q;
      if (state_q == EXEC && RDY && !illegal_q && writes_carry) c_reg_q <= ~n_COUT;
    end
  end

  // Strobe decode from state and the registered command; illegal commands keep all strobes idle.
  always_comb begin
    Z_ADD    = 1'b0;
    SB_ADD   = 1'b0;
    DB_ADD   = 1'b0;
    NDB_ADD  = 1'b0;
    ADL_ADD  = 1'b0;
    SUMS     = 1'b0;
    ANDS     = 1'b0;
    ORS      = 1'b0;
    EORS     = 1'b0;
    SRS      = 1'b0;
    n_ACIN   = 1'b1;
    n_DAA    = 1'b1;
    n_DSA    = 1'b1;
    ADD_SB06 = 1'b0;
    ADD_SB7  = 1'b0;
    ADD_ADL  = 1'b0;
    ROR_EN   = 1'b0;
    ROR_BIT7 = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    if (!illegal_q) begin
      if (state_q == LOAD && RDY) begin
        Z_ADD   = ~asrc_q;
        SB_ADD  = asrc_q;
        DB_ADD  = (bsrc_q == 2'd0);
        NDB_ADD = (bsrc_q == 2'd1);
        ADL_ADD = (bsrc_q == 2'd2);
      end
      // Op select and carry/BCD controls stay up through LOAD and EXEC, stalled or not.
      if (state_q == LOAD || state_q == EXEC) begin
        case (op_q)
          OP_SUM:         SUMS = 1'b1;
          OP_AND:         ANDS = 1'b1;
          OP_OR:          ORS  = 1'b1;
          OP_EOR:         EORS = 1'b1;
          OP_SR, OP_ROR:  SRS  = 1'b1;
          default:        ;
        endcase
        n_ACIN = ~((cin_q == 2'd1) | ((cin_q == 2'd2) & c_reg_q));
        n_DAA  = ~(dec_q & (op_q == OP_SUM) & (bsrc_q == 2'd0));
        n_DSA  = ~(dec_q & (op_q == OP_SUM) & (bsrc_q == 2'd1));
      end
      if (state_q == DRIVE && RDY) begin
        ADD_SB06 = dst_q[0];
        ADD_SB7  = dst_q[0] & ~is_ror;
        ADD_ADL  = dst_q[1];
        ROR_EN   = dst_q[0] & is_ror;
        ROR_BIT7 = dst_q[0] & is_ror & shadow_q;
      end
    end
    if (state_q == DRIVE && RDY) begin
      done = 1'b1;
      err  = illegal_q;
    end
  end

endmodule
